// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, issues req/gnt requests to instruction memory, tracks
// the PCs of in-flight requests, and buffers returned instructions so IF/ID
// sees a registered {instr, PC, PC+4, valid} head entry.
// Redirects flush everything and count the still-due responses so they can
// be discarded as they arrive.
module if_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_target_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [ILEN-1:0] imem_rdata_in,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PCPlus4_out,
  output logic            valid_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  // Each redirect adds at most DEPTH stale responses; the extra bits cover
  // a burst of redirects while the memory is slow to drain.
  localparam int DW = CW + 4;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] pend_pc [DEPTH];
  logic [PW-1:0]   pend_rd;
  logic [PW-1:0]   pend_wr;
  logic [CW-1:0]   pend_cnt;

  logic [ILEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]   buf_rd;
  logic [PW-1:0]   buf_wr;
  logic [CW-1:0]   buf_cnt;

  logic [DW-1:0]   drop_cnt;

  logic            head_valid;
  logic            pop;
  logic [OW-1:0]   occ_eff;
  logic            req;
  logic            accept;
  logic            rsp_drop;
  logic            rsp_live;
  logic            rsp_any;

  // The low target bits are forced to zero, so they never reach any state.
  logic            unused_tgt_bits;
  assign unused_tgt_bits = ^redirect_target_in[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit, handshake and response classification.
  // The head being consumed this cycle frees its credit immediately, which
  // keeps one instruction per cycle flowing with DEPTH=2 and no bubbles.
  // The request is also gated by reset so it reads 0 while reset is held.
  always_comb begin
    head_valid = (buf_cnt != '0);
    pop        = head_valid && !stall_in;
    occ_eff    = OW'(pend_cnt) + OW'(buf_cnt) - OW'(pop);
    req        = reset && !redirect_in && (occ_eff < OW'(DEPTH));
    accept     = req && imem_gnt_in;
    rsp_drop   = imem_rvalid_in && (drop_cnt != '0);
    rsp_live   = imem_rvalid_in && (drop_cnt == '0) && (pend_cnt != '0);
    rsp_any    = rsp_drop || rsp_live;
  end

  // Fetch PC: redirect wins, otherwise advance by 4 on each accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_in) begin
      fetch_pc <= {redirect_target_in[XLEN-1:2], 2'b00};
    end else if (accept) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Pending-PC queue pointers: push on accept, pop on a live response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      pend_cnt <= '0;
    end else if (redirect_in) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      pend_cnt <= '0;
    end else begin
      if (accept)   pend_wr <= ptr_inc(pend_wr);
      if (rsp_live) pend_rd <= ptr_inc(pend_rd);
      pend_cnt <= pend_cnt + CW'(accept) - CW'(rsp_live);
    end
  end

  // Output buffer pointers: push on a live response, pop when IF/ID takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_rd  <= '0;
      buf_wr  <= '0;
      buf_cnt <= '0;
    end else if (redirect_in) begin
      buf_rd  <= '0;
      buf_wr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (rsp_live) buf_wr <= ptr_inc(buf_wr);
      if (pop)      buf_rd <= ptr_inc(buf_rd);
      buf_cnt <= buf_cnt + CW'(rsp_live) - CW'(pop);
    end
  end

  // Queue and buffer storage; contents are only meaningful under the counts.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_pc[pend_wr] <= fetch_pc;
    end
    if (rsp_live && !redirect_in) begin
      buf_instr[buf_wr] <= imem_rdata_in;
      buf_pc[buf_wr]    <= pend_pc[pend_rd];
    end
  end

  // Stale-response down-counter. On redirect every pending request becomes
  // stale; a response landing in that same cycle has already been absorbed
  // (dropped or popped) and is subtracted out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (redirect_in) begin
      drop_cnt <= drop_cnt + DW'(pend_cnt) - DW'(rsp_any);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - DW'(1);
    end
  end

  // Head entry straight from the registered buffer; zeros when empty.
  always_comb begin
    imem_req_out  = req;
    imem_addr_out = fetch_pc;
    valid_out     = head_valid;
    instr_out     = head_valid ? buf_instr[buf_rd] : '0;
    PC_out        = head_valid ? buf_pc[buf_rd]    : '0;
    PCPlus4_out   = head_valid ? (buf_pc[buf_rd] + XLEN'(4)) : '0;
  end

  // A response with nothing outstanding is ignored by the logic above.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid_in && (drop_cnt == '0) && (pend_cnt == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small fixed-latency memory model.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        redirect_in;
  logic [63:0] redirect_target_in;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] pc4;
  logic        valid;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [63:0] w_pc;
  logic [63:0] w_pc4;
  logic        w_valid;

  logic        sr_v [4];
  logic [63:0] sr_a [4];
  logic [1:0]  lat_idx;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0F0F;
  endfunction

  if_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0), .DEPTH(2)) u_dut (
    .clk                (clk),
    .reset              (reset),
    .stall_in           (stall_in),
    .redirect_in        (redirect_in),
    .redirect_target_in (redirect_target_in),
    .imem_req_out       (imem_req),
    .imem_addr_out      (imem_addr),
    .imem_gnt_in        (gnt),
    .imem_rvalid_in     (rvalid),
    .imem_rdata_in      (rdata),
    .instr_out          (instr),
    .PC_out             (pc),
    .PCPlus4_out        (pc4),
    .valid_out          (valid)
  );

  if_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk                (clk),
    .reset              (reset),
    .stall_in           (1'b0),
    .redirect_in        (1'b0),
    .redirect_target_in (64'h0),
    .imem_req_out       (w_req),
    .imem_addr_out      (w_addr),
    .imem_gnt_in        (1'b1),
    .imem_rvalid_in     (w_rvalid),
    .imem_rdata_in      (w_rdata),
    .instr_out          (w_instr),
    .PC_out             (w_pc),
    .PCPlus4_out        (w_pc4),
    .valid_out          (w_valid)
  );

  // Main memory: response lat_idx+1 cycles after grant, in order.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        sr_v[i] <= 1'b0;
        sr_a[i] <= '0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        sr_v[i] <= sr_v[i-1];
        sr_a[i] <= sr_a[i-1];
      end
      sr_v[0] <= imem_req && gnt;
      sr_a[0] <= imem_addr;
    end
  end
  assign rvalid = sr_v[lat_idx];
  assign rdata  = mem_word(sr_a[lat_idx]);

  // Wrap-test memory: always grants, answers the next cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_rvalid <= 1'b0;
      w_rdata  <= '0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= mem_word(w_addr);
    end
  end

  task automatic do_reset(input logic [1:0] lat);
    reset = 1'b0;
    stall_in = 1'b0;
    redirect_in = 1'b0;
    redirect_target_in = '0;
    gnt = 1'b1;
    lat_idx = lat;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall_in = 1'b0;
    redirect_in = 1'b0;
    redirect_target_in = '0;
    gnt = 1'b1;
    lat_idx = 2'd0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
    n_vec++; if (pc !== 64'h0 || pc4 !== 64'h0) begin n_err++; $display("FAIL reset_pc got %h/%h want 0/0", pc, pc4); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL release_req got %b@%h want 1@0", imem_req, imem_addr); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_reset(2'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4*c)) begin
        n_err++; $display("FAIL basic_req c=%0d got %b@%h want 1@%h", c, imem_req, imem_addr, 64'(4*c));
      end
      n_vec++;
      if (valid !== (c >= 2)) begin n_err++; $display("FAIL basic_valid c=%0d got %b want %b", c, valid, c >= 2); end
      if (c >= 2) begin
        n_vec++;
        if (pc !== 64'(4*(c-2)) || pc4 !== 64'(4*(c-1)) || instr !== mem_word(64'(4*(c-2)))) begin
          n_err++; $display("FAIL basic_head c=%0d got %h/%h/%h want %h/%h/%h", c, pc, pc4, instr,
                            64'(4*(c-2)), 64'(4*(c-1)), mem_word(64'(4*(c-2))));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    bit          st    [11] = '{0,0,0,0,1,1,1,0,0,0,0};
    bit          req_e [11] = '{1,1,1,1,0,0,0,1,1,1,1};
    bit          val_e [11] = '{0,0,1,1,1,1,1,1,1,1,1};
    logic [63:0] adr_e [11] = '{64'h0,64'h4,64'h8,64'hC,64'h10,64'h10,64'h10,64'h10,64'h14,64'h18,64'h1C};
    logic [63:0] pc_e  [11] = '{64'h0,64'h0,64'h0,64'h4,64'h8,64'h8,64'h8,64'h8,64'hC,64'h10,64'h14};
    do_reset(2'd0);
    for (int c = 0; c < 11; c++) begin
      stall_in = st[c];
      @(negedge clk);
      n_vec++;
      if (imem_req !== req_e[c] || imem_addr !== adr_e[c]) begin
        n_err++; $display("FAIL stall_req c=%0d got %b@%h want %b@%h", c, imem_req, imem_addr, req_e[c], adr_e[c]);
      end
      n_vec++;
      if (valid !== val_e[c] || (val_e[c] && pc !== pc_e[c])) begin
        n_err++; $display("FAIL stall_head c=%0d got %b/%h want %b/%h", c, valid, pc, val_e[c], pc_e[c]);
      end
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
  endtask

  task automatic test_gnt_hold();
    bit          g     [12] = '{1,1,1,1,0,0,0,0,1,1,1,1};
    bit          val_e [12] = '{0,0,1,1,1,1,0,0,0,0,1,1};
    logic [63:0] adr_e [12] = '{64'h0,64'h4,64'h8,64'hC,64'h10,64'h10,64'h10,64'h10,64'h10,64'h14,64'h18,64'h1C};
    logic [63:0] pc_e  [12] = '{64'h0,64'h0,64'h0,64'h4,64'h8,64'hC,64'h0,64'h0,64'h0,64'h0,64'h10,64'h14};
    do_reset(2'd0);
    for (int c = 0; c < 12; c++) begin
      gnt = g[c];
      @(negedge clk);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== adr_e[c]) begin
        n_err++; $display("FAIL gnt_req c=%0d got %b@%h want 1@%h", c, imem_req, imem_addr, adr_e[c]);
      end
      n_vec++;
      if (valid !== val_e[c] || (val_e[c] && pc !== pc_e[c])) begin
        n_err++; $display("FAIL gnt_head c=%0d got %b/%h want %b/%h", c, valid, pc, val_e[c], pc_e[c]);
      end
      @(posedge clk); #1;
    end
    gnt = 1'b1;
  endtask

  task automatic test_redirect();
    bit          rd    [9] = '{0,0,1,0,0,0,0,0,0};
    bit          req_e [9] = '{1,1,0,1,1,0,0,1,1};
    bit          val_e [9] = '{0,0,0,0,0,0,0,1,1};
    logic [63:0] adr_e [9] = '{64'h0,64'h4,64'h8,64'h1000,64'h1004,64'h1008,64'h1008,64'h1008,64'h100C};
    logic [63:0] pc_e  [9] = '{64'h0,64'h0,64'h0,64'h0,64'h0,64'h0,64'h0,64'h1000,64'h1004};
    do_reset(2'd2);
    redirect_target_in = 64'h1002;
    for (int c = 0; c < 9; c++) begin
      redirect_in = rd[c];
      @(negedge clk);
      n_vec++;
      if (imem_req !== req_e[c] || imem_addr !== adr_e[c]) begin
        n_err++; $display("FAIL redir_req c=%0d got %b@%h want %b@%h", c, imem_req, imem_addr, req_e[c], adr_e[c]);
      end
      n_vec++;
      if (valid !== val_e[c] || (val_e[c] && (pc !== pc_e[c] || pc4 !== pc_e[c] + 64'h4 || instr !== mem_word(pc_e[c])))) begin
        n_err++; $display("FAIL redir_head c=%0d got %b/%h/%h want %b/%h/%h", c, valid, pc, instr, val_e[c], pc_e[c], mem_word(pc_e[c]));
      end
      @(posedge clk); #1;
    end
    redirect_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit          rd    [8] = '{0,0,0,1,1,0,0,0};
    logic [63:0] tg    [8] = '{64'h0,64'h0,64'h0,64'h2000,64'h3006,64'h0,64'h0,64'h0};
    bit          req_e [8] = '{1,1,1,0,0,1,1,1};
    bit          val_e [8] = '{0,0,1,1,0,0,0,1};
    logic [63:0] adr_e [8] = '{64'h0,64'h4,64'h8,64'hC,64'h2000,64'h3004,64'h3008,64'h300C};
    logic [63:0] pc_e  [8] = '{64'h0,64'h0,64'h0,64'h4,64'h0,64'h0,64'h0,64'h3004};
    do_reset(2'd0);
    for (int c = 0; c < 8; c++) begin
      redirect_in = rd[c];
      redirect_target_in = tg[c];
      @(negedge clk);
      n_vec++;
      if (imem_req !== req_e[c] || imem_addr !== adr_e[c]) begin
        n_err++; $display("FAIL b2b_req c=%0d got %b@%h want %b@%h", c, imem_req, imem_addr, req_e[c], adr_e[c]);
      end
      n_vec++;
      if (valid !== val_e[c] || (val_e[c] && pc !== pc_e[c])) begin
        n_err++; $display("FAIL b2b_head c=%0d got %b/%h want %b/%h", c, valid, pc, val_e[c], pc_e[c]);
      end
      @(posedge clk); #1;
    end
    redirect_in = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] adr_e [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8};
    bit          val_e [4] = '{0,0,1,1};
    logic [63:0] pc_e  [4] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    logic [63:0] p4_e  [4] = '{64'h0, 64'h0, 64'h0, 64'h4};
    do_reset(2'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== adr_e[c]) begin
        n_err++; $display("FAIL wrap_req c=%0d got %b@%h want 1@%h", c, w_req, w_addr, adr_e[c]);
      end
      n_vec++;
      if (w_valid !== val_e[c] || w_pc !== pc_e[c] || w_pc4 !== p4_e[c]) begin
        n_err++; $display("FAIL wrap_head c=%0d got %b/%h/%h want %b/%h/%h", c, w_valid, w_pc, w_pc4, val_e[c], pc_e[c], p4_e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'd0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_vec++; if (valid !== 1'b1 || pc !== 64'h4) begin n_err++; $display("FAIL mid_pre got %b/%h want 1/4", valid, pc); end
    #1 reset = 1'b0;
    #1;
    n_vec++; if (valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL mid_async got v=%b r=%b want 0/0", valid, imem_req); end
    n_vec++; if (instr !== 32'h0 || pc !== 64'h0 || pc4 !== 64'h0) begin n_err++; $display("FAIL mid_zero got %h/%h/%h want 0", instr, pc, pc4); end
    n_vec++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL mid_pc got %h want 0", imem_addr); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4*c) || valid !== (c == 2)) begin
        n_err++; $display("FAIL mid_restart c=%0d got %b@%h v=%b want 1@%h v=%b", c, imem_req, imem_addr, valid, 64'(4*c), c == 2);
      end
      @(posedge clk); #1;
    end
    n_vec++; if (pc !== 64'h4) begin n_err++; $display("FAIL mid_head got %h want 4", pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gnt_hold();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
